// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared fetch FSM state and rv32i constants
package rv32i_pkg;
    typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} fetch_state_t;
    localparam int ILEN = 32;
    localparam int PC_STEP = 4;
    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;
endpackage

// File: rtl/pc_inc.sv
// pc_inc: sequential program counter increment, wraps modulo 2^DWIDTH
module pc_inc
    import rv32i_pkg::*;
#(
    parameter int DWIDTH = 32
) (
    input  logic [DWIDTH-1:0] pc,
    output logic [DWIDTH-1:0] pc_next
);
    assign pc_next = pc + DWIDTH'(PC_STEP);
endmodule

// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding instruction fetch with redirect and decode handshake
// IFETCH_MISALIGN_CHECK_EN adds if_misaligned and parks on misaligned redirect targets
module instr_fetch
    import rv32i_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter logic [DWIDTH-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [DWIDTH-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [ILEN-1:0]   imem_rdata,
    input  logic              redirect_valid,
    input  logic [DWIDTH-1:0] redirect_pc,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [ILEN-1:0]   if_instr,
    output logic [DWIDTH-1:0] if_pc
`ifdef IFETCH_MISALIGN_CHECK_EN
    ,
    output logic              if_misaligned
`endif
);
    fetch_state_t      state;
    logic [DWIDTH-1:0] pc, pc_next, tgt;
    logic              flush;

    pc_inc #(.DWIDTH(DWIDTH)) u_pc_inc (.pc(pc), .pc_next(pc_next));

`ifdef IFETCH_MISALIGN_CHECK_EN
    assign tgt = redirect_pc;
`else
    assign tgt = redirect_pc & ~DWIDTH'(32'd3);
`endif
    assign imem_req  = state == REQ;
    assign imem_addr = pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pc       <= RESET_PC;
            flush    <= 1'b0;
            if_valid <= 1'b0;
            if_instr <= '0;
            if_pc    <= RESET_PC;
`ifdef IFETCH_MISALIGN_CHECK_EN
            if_misaligned <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: state <= REQ;
                REQ: begin
                    if (imem_gnt) state <= WAIT;
                    if (redirect_valid) begin
                        pc    <= tgt;
                        flush <= imem_gnt;
                    end else if (imem_rvalid) flush <= 1'b0;
                end
                WAIT: begin
                    if (redirect_valid) pc <= tgt;
                    else if (imem_rvalid && !flush) pc <= pc_next;
                    if (imem_rvalid) flush <= 1'b0;
                    else if (redirect_valid) flush <= 1'b1;
                    // a response is dropped if flushed earlier or redirected in its arrival cycle
                    if (imem_rvalid && (flush || redirect_valid)) state <= REQ;
                    else if (imem_rvalid) begin
                        state    <= HOLD;
                        if_valid <= 1'b1;
                        if_instr <= imem_rdata;
                        if_pc    <= pc;
                    end
                end
                HOLD: begin
                    if (redirect_valid || if_ready) begin
                        if_valid <= 1'b0;
                        state    <= REQ;
                    end
                    if (redirect_valid) pc <= tgt;
                    if (imem_rvalid) flush <= 1'b0;
                end
            endcase
`ifdef IFETCH_MISALIGN_CHECK_EN
            if (state != IDLE && redirect_valid) begin
                if_misaligned <= |redirect_pc[1:0];
                if (|redirect_pc[1:0]) begin
                    state    <= HOLD;
                    if_valid <= 1'b1;
                    if_instr <= '0;
                    if_pc    <= redirect_pc;
                end
            end else if (state == HOLD && if_misaligned) begin
                state    <= HOLD;
                if_valid <= 1'b1;
            end
`endif
        end
    end
endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: directed self-checking bench for instr_fetch
module tb_instr_fetch;
    import rv32i_pkg::*;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req, imem_gnt = 1'b0, imem_rvalid = 1'b0;
    logic [31:0] imem_addr, imem_rdata = '0, redirect_pc = '0, if_instr, if_pc;
    logic        redirect_valid = 1'b0, if_valid, if_ready = 1'b1;
`ifdef IFETCH_MISALIGN_CHECK_EN
    logic        if_misaligned;
`endif
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    instr_fetch #(.DWIDTH(32), .RESET_PC(32'h100)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc)
`ifdef IFETCH_MISALIGN_CHECK_EN
        , .if_misaligned(if_misaligned)
`endif
    );

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b want=0", imem_req); end
        checks++; if (imem_addr !== 32'h100) begin failures++; $display("FAIL reset_addr got=%h want=00000100", imem_addr); end
        checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b want=0", if_valid); end
        checks++; if (if_instr !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h want=0", if_instr); end
        checks++; if (if_pc !== 32'h100) begin failures++; $display("FAIL reset_pc got=%h want=00000100", if_pc); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin failures++; $display("FAIL first_req got=%b/%h want=1/00000100", imem_req, imem_addr); end
    endtask

    task automatic test_stream();
        time t_prev = 0;
        if_ready = 1'b1;
        for (int n = 0; n < 3; n++) begin
            checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100 + 32'(4*n)) begin failures++; $display("FAIL stream_req%0d got=%b/%h want=1/%h", n, imem_req, imem_addr, 32'h100 + 32'(4*n)); end
            imem_gnt = 1'b1;
            @(negedge clk);
            imem_gnt = 1'b0;
            checks++; if (imem_req !== 1'b0 || if_valid !== 1'b0) begin failures++; $display("FAIL stream_wait%0d got=%b/%b want=0/0", n, imem_req, if_valid); end
            imem_rvalid = 1'b1; imem_rdata = 32'hA0 + 32'(n);
            @(negedge clk);
            imem_rvalid = 1'b0;
            checks++; if (if_valid !== 1'b1 || if_instr !== 32'hA0 + 32'(n) || if_pc !== 32'h100 + 32'(4*n)) begin failures++; $display("FAIL stream_out%0d got=%b/%h/%h want=1/%h/%h", n, if_valid, if_instr, if_pc, 32'hA0 + 32'(n), 32'h100 + 32'(4*n)); end
            if (n > 0) begin
                checks++; if ($time - t_prev != 30) begin failures++; $display("FAIL stream_gap%0d got=%0t want=30", n, $time - t_prev); end
            end
            t_prev = $time;
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h10C) begin failures++; $display("FAIL bp_req got=%b/%h want=1/0000010c", imem_req, imem_addr); end
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0; if_ready = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hB0;
        @(negedge clk);
        imem_rvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++; if (if_valid !== 1'b1 || if_instr !== 32'hB0 || if_pc !== 32'h10C || imem_req !== 1'b0) begin failures++; $display("FAIL bp_hold%0d got=%b/%h/%h/%b want=1/b0/10c/0", i, if_valid, if_instr, if_pc, imem_req); end
            @(negedge clk);
        end
        checks++; if (if_valid !== 1'b1 || imem_req !== 1'b0) begin failures++; $display("FAIL bp_still got=%b/%b want=1/0", if_valid, imem_req); end
        if_ready = 1'b1;
        @(negedge clk);
        checks++; if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h110) begin failures++; $display("FAIL bp_release got=%b/%b/%h want=0/1/00000110", if_valid, imem_req, imem_addr); end
    endtask

    task automatic test_redirect_wait();
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h200;
        @(negedge clk);
        redirect_valid = 1'b0;
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL rw_wait got=%b want=0", imem_req); end
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD;
        @(negedge clk);
        imem_rvalid = 1'b0;
        checks++; if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h200) begin failures++; $display("FAIL rw_drop got=%b/%b/%h want=0/1/00000200", if_valid, imem_req, imem_addr); end
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hC0;
        @(negedge clk);
        imem_rvalid = 1'b0;
        checks++; if (if_valid !== 1'b1 || if_instr !== 32'hC0 || if_pc !== 32'h200) begin failures++; $display("FAIL rw_out got=%b/%h/%h want=1/c0/200", if_valid, if_instr, if_pc); end
        @(negedge clk);
    endtask

    task automatic test_wrap_and_simultaneous();
        redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        redirect_valid = 1'b0;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_redir got=%b/%h want=1/fffffffc", imem_req, imem_addr); end
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hE0;
        @(negedge clk);
        imem_rvalid = 1'b0;
        checks++; if (if_valid !== 1'b1 || if_instr !== 32'hE0 || if_pc !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_out got=%b/%h/%h want=1/e0/fffffffc", if_valid, if_instr, if_pc); end
        @(negedge clk);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL wrap_addr got=%b/%h want=1/00000000", imem_req, imem_addr); end
        imem_gnt = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h300;
        @(negedge clk);
        imem_gnt = 1'b0; redirect_valid = 1'b0;
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL sim_wait got=%b want=0", imem_req); end
        imem_rvalid = 1'b1; imem_rdata = 32'hBAD;
        @(negedge clk);
        imem_rvalid = 1'b0;
        checks++; if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h300) begin failures++; $display("FAIL sim_drop got=%b/%b/%h want=0/1/00000300", if_valid, imem_req, imem_addr); end
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hF0;
        @(negedge clk);
        imem_rvalid = 1'b0;
        checks++; if (if_valid !== 1'b1 || if_instr !== 32'hF0 || if_pc !== 32'h300) begin failures++; $display("FAIL sim_out got=%b/%h/%h want=1/f0/300", if_valid, if_instr, if_pc); end
        @(negedge clk);
    endtask

    task automatic test_misalign();
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h304) begin failures++; $display("FAIL mis_pre got=%b/%h want=1/00000304", imem_req, imem_addr); end
        redirect_valid = 1'b1; redirect_pc = 32'h202;
        @(negedge clk);
        redirect_valid = 1'b0;
`ifdef IFETCH_MISALIGN_CHECK_EN
        repeat (2) @(negedge clk);
        checks++; if (if_misaligned !== 1'b1 || imem_req !== 1'b0 || if_valid !== 1'b1 || if_instr !== 32'h0) begin failures++; $display("FAIL mis_flag got=%b/%b/%b/%h want=1/0/1/0", if_misaligned, imem_req, if_valid, if_instr); end
        redirect_valid = 1'b1; redirect_pc = 32'h400;
        @(negedge clk);
        redirect_valid = 1'b0;
        checks++; if (if_misaligned !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h400) begin failures++; $display("FAIL mis_clear got=%b/%b/%h want=0/1/00000400", if_misaligned, imem_req, imem_addr); end
`else
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin failures++; $display("FAIL mis_align got=%b/%h want=1/00000200", imem_req, imem_addr); end
`endif
    endtask

    task automatic test_reset_mid();
        imem_gnt = 1'b1;
        @(negedge clk);
        imem_gnt = 1'b0; rst = 1'b1;
        @(negedge clk);
        checks++; if (imem_req !== 1'b0 || if_valid !== 1'b0 || imem_addr !== 32'h100) begin failures++; $display("FAIL rmid_reset got=%b/%b/%h want=0/0/00000100", imem_req, if_valid, imem_addr); end
        rst = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h5A5A;
        @(negedge clk);
        imem_rvalid = 1'b0;
        checks++; if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h100 || if_instr !== 32'h0) begin failures++; $display("FAIL rmid_late got=%b/%b/%h/%h want=0/1/100/0", if_valid, imem_req, imem_addr, if_instr); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_wait();
        test_wrap_and_simultaneous();
        test_misalign();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch unit for the rv32i core: owns the architectural program counter and issues fetch requests to instruction memory, one outstanding at a time. It delivers each returned instruction word and its PC to decode over a valid/ready handshake. A branch/jump redirect from execute replaces the sequential PC at any point. It consumes the increment produced by `pc_inc` and drives the address that `pc_inc` is fed from.

## Interface
- `DWIDTH`, 32, PC / address width
- `RESET_PC`, 0, PC loaded on reset
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `imem_req`  out  1  fetch request
- `imem_addr`  out  DWIDTH  fetch address; stable while `imem_req` is high without grant, unless redirected
- `imem_gnt`  in  1  request accepted this cycle
- `imem_rvalid`  in  1  read data valid
- `imem_rdata`  in  32  instruction word
- `redirect_valid`  in  1  load new PC
- `redirect_pc`  in  DWIDTH  redirect target
- `if_valid`  out  1  instruction available to decode
- `if_ready`  in  1  decode accepts
- `if_instr`  out  32  instruction word
- `if_pc`  out  DWIDTH  PC of `if_instr`

## Operation
- FSM states: IDLE, REQ, WAIT, HOLD.
  - IDLE: entered only by reset; moves to REQ on the next cycle. `imem_rvalid` is ignored here.
  - REQ: `imem_req`=1, `imem_addr`=pc. On `imem_gnt`, go to WAIT.
  - WAIT: `imem_req`=0. On `imem_rvalid` (not flushed): capture `if_instr`=`imem_rdata` and `if_pc`=pc, set `if_valid`=1, set pc=pc+4, go to HOLD.
  - HOLD: `if_valid` stays high and outputs stay stable until `if_valid && if_ready`. Then `if_valid`=0 and the FSM goes to REQ.
- Sequential increment is pc+4 modulo 2^DWIDTH; 0xFFFF_FFFC wraps to 0x0000_0000.
- Redirect (`redirect_valid`=1) has priority over sequential update in every state except IDLE:
  - REQ without `imem_gnt`: pc=`redirect_pc`; stay in REQ; new address on the next cycle.
  - REQ with `imem_gnt` in the same cycle: the old address is granted; set the flush flag; pc=`redirect_pc`; go to WAIT.
  - WAIT: set the flush flag; pc=`redirect_pc`. A flushed `imem_rvalid` (including one arriving in the redirect cycle) is discarded, the flag clears, and the FSM goes to REQ.
  - HOLD: `if_valid`=0 next cycle; go to REQ with the new pc. A simultaneous `if_ready` handshake still completes; nothing extra is dropped.
- Reset mid-transaction abandons the outstanding request. A late `imem_rvalid` is ignored while in IDLE.

## Timing
- Reset values: `imem_req`=0, `imem_addr`=`RESET_PC`, `if_valid`=0, `if_instr`=0, `if_pc`=`RESET_PC`, flush flag=0, state=IDLE.
- First `imem_req` occurs in the 2nd cycle after `rst` falls.
- With zero-wait memory (`gnt` in the same cycle, `rvalid` the next) and `if_ready` held high: one instruction per 3 cycles (REQ, WAIT, HOLD).
- `imem_rvalid` to `if_valid`: 1 cycle (registered).
- Redirect to new `imem_addr`: 1 cycle, unless a response is still outstanding.

## Configuration
- `IFETCH_MISALIGN_CHECK_EN` defined:
  - Adds output `if_misaligned` (1 bit, reset 0).
  - A redirect with `redirect_pc[1:0]`≠0 sets `if_misaligned`=1, loads pc with the target, and parks the FSM in HOLD with `if_valid`=1 and `if_instr`=0. No memory request is made.
  - Cleared by the next redirect or by reset.
- Undefined: `redirect_pc[1:0]` is forced to 0 when loaded; no extra port.

## Structure
- Shared package `rv32i_pkg`: fetch FSM state enum, `ILEN`=32, `PC_STEP`=4, `NOP_INSTR`=32'h0000_0013 (for benches).
- One sub-module instance: `pc_inc` with `DWIDTH` passed through, computing pc+4. No other hierarchy.

## Test plan
- Reset: hold `rst` 3 cycles, `RESET_PC`=0x100 -> all outputs at reset values; `imem_req`=1 with `imem_addr`=0x100 two cycles after release.
- Sequential stream: zero-wait memory returning 0xA0+n, `if_ready`=1 -> `if_pc` = 0x100, 0x104, 0x108, each `if_valid` pulse 3 cycles apart.
- Backpressure: `if_ready`=0 for 5 cycles in HOLD -> `if_instr`/`if_pc` stable, `imem_req`=0, next request only after the handshake.
- Redirect in WAIT: redirect to 0x200 while a response is outstanding -> the returned word is dropped, next `imem_addr`=0x200, next `if_pc`=0x200.
- Wrap plus simultaneous events: pc=0xFFFF_FFFC fetched -> next address 0x0. Redirect and `imem_gnt` in the same cycle -> old address granted, its data discarded, then a fetch from the target.
- Macro build: redirect to 0x202 -> with `IFETCH_MISALIGN_CHECK_EN`, `if_misaligned`=1 and no `imem_req`; without it, `imem_addr`=0x200.
